fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the fixed single-cycle PC register and combinational instruction-memory read with a handshaked, latency-tolerant fetch path. It issues in-order requests to instruction memory, buffers returned instructions with their PC in a prefetch queue, and presents them to decode under a valid/ready handshake. On a branch or jump redirect it flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_prefetch_unit_sync_fifo.sv | 58 +++++
 rtl/fetch_prefetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is read from storage registers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Wrap explicitly so depths that are not a power of two still work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Handshaked instruction-fetch front end: credit-limited in-order requests, prefetch queue, redirect flush.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int             DW              = 32,
  parameter int             DEPTH           = DEFAULT_DEPTH,
  parameter int             MAX_OUTSTANDING = 2,
  parameter logic [DW-1:0]  RESET_PC        = '0,
  parameter int             ADDENT          = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  input  logic          redirect_i,
  input  logic [DW-1:0] redirect_pc_i,
  output logic          instr_valid_o,
  input  logic          instr_ready_i,
  output logic [DW-1:0] instr_o,
  output logic [DW-1:0] pc_o,
  output logic [DW-1:0] pc_plus_4_o
);

  localparam int CW = credit_width(DEPTH);
  localparam int OW = credit_width(MAX_OUTSTANDING);

  logic [DW-1:0] fetch_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_next;
  logic [OW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [DW-1:0] tag_pc;
  logic          issue;
  logic          rsp;
  logic          push;
  logic          pop;
  logic          room;
  logic          q_empty;
  logic          q_full_unused;
  logic          tag_full_unused;
  logic          tag_empty_unused;
  logic [OW-1:0] tag_count_unused;

  // Queue space is reserved for every live request, so a granted response always fits.
  assign room = (32'(count) + 32'(outstanding) - 32'(drop_cnt)) < 32'(DEPTH);

  assign imem_req_o  = !rst_i & !redirect_i & (32'(outstanding) < 32'(MAX_OUTSTANDING)) & room;
  assign imem_addr_o = fetch_pc;
  assign issue       = imem_req_o & imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp         = imem_rvalid_i & (outstanding != '0);
  assign push        = rsp & !redirect_i & (drop_cnt == '0);
  assign pop         = instr_valid_o & instr_ready_i & !redirect_i;

  assign outstanding_next = outstanding + OW'(issue) - OW'(rsp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC & ~DW'(3);
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_i) begin
        fetch_pc <= redirect_pc_i & ~DW'(3);
        drop_cnt <= outstanding_next;
      end else begin
        if (issue) fetch_pc <= fetch_pc + DW'(ADDENT);
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  // Tags are popped for every response, dropped or not, so they stay aligned with memory order.
  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (rsp),
    .flush     (1'b0),
    .head      (tag_pc),
    .full      (tag_full_unused),
    .empty     (tag_empty_unused),
    .count     (tag_count_unused)
  );

  sync_fifo #(
    .WIDTH (2 * DW),
    .DEPTH (DEPTH)
  ) u_instr_queue (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data ({imem_rdata_i, tag_pc}),
    .pop       (pop),
    .flush     (redirect_i),
    .head      ({instr_o, pc_o}),
    .full      (q_full_unused),
    .empty     (q_empty),
    .count     (count)
  );

  assign instr_valid_o = !q_empty;
  assign pc_plus_4_o   = pc_o + DW'(ADDENT);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit against a queue-based reference of the fetch rules.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_4_o;

  fetch_prefetch_unit #(
    .DW              (32),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RESET_PC),
    .ADDENT          (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus_4_o   (pc_plus_4_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // In-flight requests carry a stale mark instead of a drop counter.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } infl_t;

  infl_t        infl[$];
  fetch_entry_t q[$];
  logic [31:0]  model_pc;
  int           cyc;
  int           lat;
  int           checks;
  int           passed;
  bit           last_valid;
  bit           last_req;
  logic [31:0]  last_pc;
  logic [31:0]  last_pc4;
  logic [31:0]  last_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic applyStimulus(input bit rst, input bit gnt, input bit ready, input bit redir,
                               input logic [31:0] rpc, input bit spur);
    bit           due;
    bit           exp_req;
    int           live;
    infl_t        e;
    fetch_entry_t ent;
    @(negedge clk_i);
    due = !rst && infl.size() > 0 && infl[0].due <= cyc;
    rst_i         = rst;
    imem_gnt_i    = gnt;
    instr_ready_i = ready;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_rvalid_i = due || (spur && !rst && infl.size() == 0);
    imem_rdata_i  = due ? mem_data(infl[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (infl[i]) if (!infl[i].stale) live++;
    exp_req = !rst && !redir && infl.size() < MAXO && (q.size() + live) < DEPTH;
    checkOutput("req", 32'(imem_req_o), 32'(exp_req));
    checkOutput("addr", imem_addr_o, model_pc);
    checkOutput("addr_align", imem_addr_o & 32'h3, 32'h0);
    checkOutput("valid", 32'(instr_valid_o), 32'(q.size() > 0));
    if (q.size() > 0) begin
      checkOutput("pc", pc_o, q[0].pc);
      checkOutput("instr", instr_o, q[0].instr);
      checkOutput("pc_plus_4", pc_plus_4_o, q[0].pc + 32'd4);
    end
    last_valid = instr_valid_o;
    last_req   = imem_req_o;
    last_pc    = pc_o;
    last_pc4   = pc_plus_4_o;
    last_addr  = imem_addr_o;
    if (rst) begin
      q.delete();
      infl.delete();
      model_pc = RESET_PC;
    end else begin
      if (q.size() > 0 && ready && !redir) void'(q.pop_front());
      if (due) begin
        e = infl.pop_front();
        if (!e.stale && !redir) begin
          ent.instr = mem_data(e.addr);
          ent.pc    = e.addr;
          q.push_back(ent);
        end
      end
      if (redir) begin
        q.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
        model_pc = rpc & ~32'h3;
      end else if (exp_req && gnt) begin
        e.addr  = model_pc;
        e.due   = cyc + lat;
        e.stale = 1'b0;
        infl.push_back(e);
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk_i);
    cyc++;
  endtask

  initial begin
    int first;
    int pops;
    bit found;
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
    checks = 0; passed = 0; cyc = 0; lat = 1; model_pc = RESET_PC;

    // Reset values while reset is still held.
    repeat (3) applyStimulus(1, 1, 1, 0, 0, 0);
    @(negedge clk_i); #1;
    checkOutput("rst_req", 32'(imem_req_o), 32'h0);
    checkOutput("rst_valid", 32'(instr_valid_o), 32'h0);
    checkOutput("rst_instr", instr_o, 32'h0);
    checkOutput("rst_pc", pc_o, 32'h0);
    checkOutput("rst_pc_plus_4", pc_plus_4_o, 32'h4);
    checkOutput("rst_addr", imem_addr_o, RESET_PC);
    @(posedge clk_i); cyc++;

    // Streaming at L=1: first instruction in the third cycle after release.
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 1, 1, 0, 0, 0);
      if (last_valid && first == 0) first = k;
    end
    checkOutput("first_valid_cycle", first, 3);

    // Decode stall fills exactly DEPTH entries, then drains in order.
    repeat (10) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("stall_req", 32'(last_req), 32'h0);
    pops = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 0);
      if (last_valid) pops++;
    end
    checkOutput("stall_buffered", pops, DEPTH);

    // L=3 redirect with two requests in flight.
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
    lat = 3;
    repeat (2) applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h103, 0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      found = last_valid;
    end
    checkOutput("redir_found", 32'(found), 32'h1);
    checkOutput("redir_pc", last_pc, 32'h100);
    checkOutput("redir_pc_plus_4", last_pc4, 32'h104);

    // Redirect coinciding with a response and a pop.
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
    lat = 1;
    repeat (2) applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h40, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("flush_valid", 32'(last_valid), 32'h0);

    // Spurious responses with nothing outstanding, then resume.
    repeat (4) applyStimulus(0, 0, 1, 0, 0, 1);
    repeat (6) applyStimulus(0, 1, 1, 0, 0, 0);

    // Reset with a full queue and requests in flight.
    lat = 3;
    repeat (12) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("midrst_valid", 32'(last_valid), 32'h0);
    checkOutput("midrst_addr", last_addr, RESET_PC);

    for (int k = 0; k < 1000; k++) begin
      if (k % 200 == 0) lat = $urandom_range(1, 3);
      applyStimulus(($urandom % 400) == 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
                    ($urandom % 20) == 0, $urandom, ($urandom % 8) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
